// File: rtl/alu_control_mc_if.sv
// Handshake and result bus between the main control unit, the ALU function
// sequencer and the ALU/MDU.
interface alu_control_mc_if #(
    parameter int FUNC_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [FUNC_W-1:0] funct;
    logic              out_valid;
    logic [FUNC_W-1:0] alu_func;
    logic              mdu_start;
    logic              busy;

    modport master (
        output in_valid, alu_op, funct,
        input  in_ready, out_valid, alu_func, mdu_start, busy
    );

    modport slave (
        input  in_valid, alu_op, funct,
        output in_ready, out_valid, alu_func, mdu_start, busy
    );
endinterface

// File: rtl/alu_control_mc.sv
// Registered ALU function decoder with multi-cycle sequencing of MULT/DIV ops.
// Build option: ALU_CTRL_BRANCH_EN makes alu_op 01 decode to SUB instead of ADD.
//
// state | meaning
// IDLE  | ready for a new op; single-cycle ops complete here
// WAIT  | MDU op in flight, cnt counts down to the result edge
module alu_control_mc #(
    parameter int FUNC_W     = 6,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input logic               clk,
    input logic               rst,
    alu_control_mc_if.slave   bus
);
    localparam logic [FUNC_W-1:0] F_ADD   = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] F_SUB   = FUNC_W'(6'b100010);
    localparam logic [FUNC_W-1:0] F_MULT  = FUNC_W'(6'b011000);
    localparam logic [FUNC_W-1:0] F_MULTU = FUNC_W'(6'b011001);
    localparam logic [FUNC_W-1:0] F_DIV   = FUNC_W'(6'b011010);
    localparam logic [FUNC_W-1:0] F_DIVU  = FUNC_W'(6'b011011);

`ifdef ALU_CTRL_BRANCH_EN
    localparam logic [FUNC_W-1:0] F_BRANCH = F_SUB;
`else
    localparam logic [FUNC_W-1:0] F_BRANCH = F_ADD;
`endif

    // Loaded value is latency-2: the accept edge and the result edge bracket the count.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              busy_q, busy_nxt;
    logic              out_valid_q, out_valid_nxt;
    logic [FUNC_W-1:0] alu_func_q, alu_func_nxt;
    logic [FUNC_W-1:0] funct_lat, funct_lat_nxt;

    logic              accept;
    logic              is_mdu;
    logic              is_mul;
    logic [FUNC_W-1:0] decode;

    assign bus.in_ready  = (state == IDLE) & ~rst;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.mdu_start = accept & is_mdu;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_func  = alu_func_q;
    assign bus.busy      = busy_q;

    always_comb begin
        decode = F_ADD;
        case (bus.alu_op)
            2'b01:   decode = F_BRANCH;
            2'b10:   decode = bus.funct;
            default: decode = F_ADD;
        endcase
    end

    assign is_mdu = (bus.alu_op == 2'b10) &&
                    ((bus.funct == F_MULT) || (bus.funct == F_MULTU) ||
                     (bus.funct == F_DIV)  || (bus.funct == F_DIVU));
    assign is_mul = (bus.funct == F_MULT) || (bus.funct == F_MULTU);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        busy_nxt      = busy_q;
        out_valid_nxt = 1'b0;
        alu_func_nxt  = alu_func_q;
        funct_lat_nxt = funct_lat;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mdu) begin
                        state_nxt     = WAIT;
                        cnt_nxt       = is_mul ? MUL_LOAD : DIV_LOAD;
                        busy_nxt      = 1'b1;
                        funct_lat_nxt = bus.funct;
                    end else begin
                        out_valid_nxt = 1'b1;
                        alu_func_nxt  = decode;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt     = IDLE;
                    busy_nxt      = 1'b0;
                    out_valid_nxt = 1'b1;
                    alu_func_nxt  = funct_lat;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            alu_func_q  <= F_ADD;
            funct_lat   <= F_ADD;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            busy_q      <= busy_nxt;
            out_valid_q <= out_valid_nxt;
            alu_func_q  <= alu_func_nxt;
            funct_lat   <= funct_lat_nxt;
        end
    end
endmodule
